// File: rtl/iomem_stream_pkg.sv
// Shared constants for the iomem stream FIFO peripheral: register map, STATUS/CTRL layout.
package iomem_stream_pkg;

  localparam logic [7:0] ADDR_HI_DEF = 8'h04;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_RXDATA = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam logic [1:0] OFF_CTRL   = 2'd3;

  localparam int unsigned ST_TX_FULL  = 0;
  localparam int unsigned ST_TX_EMPTY = 1;
  localparam int unsigned ST_RX_FULL  = 2;
  localparam int unsigned ST_RX_EMPTY = 3;
  localparam int unsigned ST_TX_OVF   = 4;
  localparam int unsigned ST_RX_UNF   = 5;
  localparam int unsigned ST_TX_LVL   = 8;
  localparam int unsigned ST_RX_LVL   = 16;

  localparam int unsigned CT_TX_EN     = 0;
  localparam int unsigned CT_RX_IRQ_EN = 1;
  localparam int unsigned CT_FLUSH     = 2;

  // STATUS read word; last member is bit 0
  typedef struct packed {
    logic [7:0] rsvd_hi;
    logic [7:0] rx_level;
    logic [7:0] tx_level;
    logic [1:0] rsvd_lo;
    logic       rx_unf;
    logic       tx_ovf;
    logic       rx_empty;
    logic       rx_full;
    logic       tx_empty;
    logic       tx_full;
  } status_t;

endpackage

// File: rtl/iomem_stream_fifo_sync_fifo.sv
// Single-clock show-ahead FIFO with extra-MSB pointers; flush overrides push/pop.
module sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [7:0]       level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign level_o = 8'(wptr_q - rptr_q);
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  // Full/empty are pre-edge, so a push to a full FIFO is refused even alongside a pop
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PW'(1);
      if (do_pop)  rptr_d = rptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/iomem_stream_fifo.sv
// iomem slave bridging CPU register accesses to a TX and an RX word stream.
module iomem_stream_fifo
  import iomem_stream_pkg::*;
#(
  parameter logic [7:0]  ADDR_HI = ADDR_HI_DEF,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iomem_valid,
  output logic              iomem_ready,
  input  logic [3:0]        iomem_wstrb,
  input  logic [31:0]       iomem_addr,
  input  logic [31:0]       iomem_wdata,
  output logic [31:0]       iomem_rdata,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_ready,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic              rx_ready,
  output logic              irq
);

  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic        tx_en_q, tx_en_d, irq_en_q, irq_en_d;
  logic        tx_ovf_q, tx_ovf_d, rx_unf_q, rx_unf_d;
  logic        irq_q, irq_d;

  logic        hit, wr, flush_c;
  logic [1:0]  off;
  logic [31:0] tx_wdata;
  logic        tx_full, tx_empty, rx_full, rx_empty;
  logic [7:0]  tx_level, rx_level;
  logic [DATA_W-1:0] tx_head, rx_head;
  status_t     status;
  logic        unused_addr;

  assign unused_addr = ^{iomem_addr[23:4], iomem_addr[1:0]};

  assign hit     = iomem_valid & ~ready_q & (iomem_addr[31:24] == ADDR_HI);
  assign off     = iomem_addr[3:2];
  assign wr      = |iomem_wstrb;
  assign flush_c = hit & (off == OFF_CTRL) & iomem_wstrb[0] & iomem_wdata[CT_FLUSH];

  // Unstrobed byte lanes are pushed as zero
  always_comb begin
    for (int b = 0; b < 4; b++) tx_wdata[8*b +: 8] = iomem_wstrb[b] ? iomem_wdata[8*b +: 8] : 8'h00;
  end

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_W)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (hit & (off == OFF_TXDATA) & wr),
    .pop_i   (tx_valid & tx_ready),
    .flush_i (flush_c),
    .wdata_i (tx_wdata),
    .head_o  (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .level_o (tx_level)
  );

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_W)) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (rx_valid & rx_ready),
    .pop_i   (hit & (off == OFF_RXDATA) & ~wr),
    .flush_i (flush_c),
    .wdata_i (rx_data),
    .head_o  (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .level_o (rx_level)
  );

  always_comb begin
    status          = '0;
    status.tx_full  = tx_full;
    status.tx_empty = tx_empty;
    status.rx_full  = rx_full;
    status.rx_empty = rx_empty;
    status.tx_ovf   = tx_ovf_q;
    status.rx_unf   = rx_unf_q;
    status.tx_level = tx_level;
    status.rx_level = rx_level;
  end

  // Register decode: all side effects land on the edge that samples the hit
  always_comb begin
    ready_d  = hit;
    rdata_d  = '0;
    tx_en_d  = tx_en_q;
    irq_en_d = irq_en_q;
    tx_ovf_d = tx_ovf_q;
    rx_unf_d = rx_unf_q;
    irq_d    = irq_en_q & ~rx_empty;
    if (hit) begin
      unique case (off)
        OFF_TXDATA: if (wr && tx_full) tx_ovf_d = 1'b1;
        OFF_RXDATA: begin
          if (!wr) begin
            if (rx_empty) rx_unf_d = 1'b1;
            else          rdata_d  = 32'(rx_head);
          end
        end
        OFF_STATUS: begin
          if (!wr) rdata_d = status;
          if (iomem_wstrb[0]) begin
            if (iomem_wdata[ST_TX_OVF]) tx_ovf_d = 1'b0;
            if (iomem_wdata[ST_RX_UNF]) rx_unf_d = 1'b0;
          end
        end
        OFF_CTRL: begin
          if (!wr) rdata_d = {30'd0, irq_en_q, tx_en_q};
          if (iomem_wstrb[0]) begin
            tx_en_d  = iomem_wdata[CT_TX_EN];
            irq_en_d = iomem_wdata[CT_RX_IRQ_EN];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      tx_en_q  <= 1'b0;
      irq_en_q <= 1'b0;
      tx_ovf_q <= 1'b0;
      rx_unf_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
      tx_en_q  <= tx_en_d;
      irq_en_q <= irq_en_d;
      tx_ovf_q <= tx_ovf_d;
      rx_unf_q <= rx_unf_d;
      irq_q    <= irq_d;
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign tx_valid    = tx_en_q & ~tx_empty;
  assign tx_data     = tx_head;
  assign rx_ready    = ~rx_full;
  assign irq         = irq_q;

endmodule
